// File: rtl/simd_cfg_bridge.sv
// rtl/simd_cfg_bridge.sv - PE shadow config regs, commit FIFO and stOp dispatch with outstanding tracking (optional readback: SIMD_CFG_BRIDGE_READBACK_EN)
`ifndef PE_PE_ID_RANGE
`define PE_PE_ID_RANGE 7:0
`endif

module simd_cfg_bridge #(
  parameter int NUM_LANES       = 32,
  parameter int REG_WIDTH       = 32,
  parameter int NUM_REGS        = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 15,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk,
  input  logic                          reset_poweron,
  input  logic [`PE_PE_ID_RANGE]        peId,
  input  logic                          cntl__simd__wr_valid,
  input  logic [AW-1:0]                 cntl__simd__wr_addr,
  input  logic [REG_WIDTH-1:0]          cntl__simd__wr_data,
  input  logic                          cntl__simd__commit,
  input  logic [NUM_LANES-1:0]          cntl__simd__lane_mask,
  output logic                          simd__cntl__busy,
  output logic                          simd__cntl__idle,
  output logic                          simd__cntl__commit_drop,
  output logic                          simd__cntl__err,
  output logic                          simd__stOp__valid,
  output logic [NUM_REGS*REG_WIDTH-1:0] simd__stOp__cfg,
  output logic [NUM_LANES-1:0]          simd__stOp__lane_en,
  output logic [7:0]                    simd__stOp__tag,
  input  logic                          stOp__simd__ready,
  input  logic                          stOp__simd__done
`ifdef SIMD_CFG_BRIDGE_READBACK_EN
  ,
  input  logic [AW-1:0]                 cntl__simd__rd_addr,
  output logic [REG_WIDTH-1:0]          simd__cntl__rd_data
`endif
);

  localparam int CFG_W = NUM_REGS * REG_WIDTH;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  logic [REG_WIDTH-1:0] shadow_q   [NUM_REGS];
  logic [REG_WIDTH-1:0] shadow_d   [NUM_REGS];
  logic [CFG_W-1:0]     cfg_mem_q  [FIFO_DEPTH];
  logic [CFG_W-1:0]     cfg_mem_d  [FIFO_DEPTH];
  logic [NUM_LANES-1:0] lane_mem_q [FIFO_DEPTH];
  logic [NUM_LANES-1:0] lane_mem_d [FIFO_DEPTH];
  logic [7:0]           tag_mem_q  [FIFO_DEPTH];
  logic [7:0]           tag_mem_d  [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [7:0]           seq_q, seq_d;
  logic [OW-1:0]        outst_q, outst_d;
  logic                 err_q, err_d;
  logic                 commit_drop_q, commit_drop_d;
  logic [CFG_W-1:0]     snap;
  logic                 fifo_empty, fifo_full, out_limit, valid, pop, push;

  // The PE id is not carried in the payload; keep it visibly consumed.
  logic unused_peid;
  assign unused_peid = ^peId;

  // Shadow register update; the snapshot sees a same-cycle write (write-through).
  always_comb begin
    shadow_d = shadow_q;
    snap     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cntl__simd__wr_valid && (32'(cntl__simd__wr_addr) == i)) shadow_d[i] = cntl__simd__wr_data;
      snap[i*REG_WIDTH +: REG_WIDTH] = shadow_d[i];
    end
  end

  // Handshake qualifiers: dispatch is throttled by the outstanding limit.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    out_limit  = (outst_q == OW'(MAX_OUTSTANDING));
    valid      = !fifo_empty && !out_limit;
    pop        = valid && stOp__simd__ready;
    push       = cntl__simd__commit && (!fifo_full || pop);
  end

  // Circular snapshot FIFO plus commit sequence numbering.
  always_comb begin
    cfg_mem_d     = cfg_mem_q;
    lane_mem_d    = lane_mem_q;
    tag_mem_d     = tag_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    seq_d         = seq_q;
    commit_drop_d = cntl__simd__commit && !push;
    if (push) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (32'(wr_ptr_q) == j) begin
          cfg_mem_d[j]  = snap;
          lane_mem_d[j] = cntl__simd__lane_mask;
          tag_mem_d[j]  = seq_q;
        end
      end
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      seq_d    = seq_q + 8'd1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Outstanding-op accounting; a done with nothing in flight is flagged sticky.
  always_comb begin
    outst_d = outst_q;
    err_d   = err_q;
    case ({pop, stOp__simd__done})
      2'b10: outst_d = outst_q + OW'(1);
      2'b01: begin
        if (outst_q == '0) err_d = 1'b1;
        else               outst_d = outst_q - OW'(1);
      end
      default: outst_d = outst_q;
    endcase
  end

  // State registers; memories are cleared so outputs read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        cfg_mem_q[j]  <= '0;
        lane_mem_q[j] <= '0;
        tag_mem_q[j]  <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      seq_q         <= '0;
      outst_q       <= '0;
      err_q         <= 1'b0;
      commit_drop_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      cfg_mem_q     <= cfg_mem_d;
      lane_mem_q    <= lane_mem_d;
      tag_mem_q     <= tag_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      seq_q         <= seq_d;
      outst_q       <= outst_d;
      err_q         <= err_d;
      commit_drop_q <= commit_drop_d;
    end
  end

  assign simd__cntl__busy        = fifo_full;
  assign simd__cntl__idle        = fifo_empty && (outst_q == '0);
  assign simd__cntl__commit_drop = commit_drop_q;
  assign simd__cntl__err         = err_q;
  assign simd__stOp__valid       = valid;
  assign simd__stOp__cfg         = cfg_mem_q[rd_ptr_q];
  assign simd__stOp__lane_en     = lane_mem_q[rd_ptr_q];
  assign simd__stOp__tag         = tag_mem_q[rd_ptr_q];

`ifdef SIMD_CFG_BRIDGE_READBACK_EN
  logic [REG_WIDTH-1:0] rd_data_q, rd_data_d;

  // Registered readback of the committed shadow value; out-of-range reads give 0.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(cntl__simd__rd_addr) == i) rd_data_d = shadow_q[i];
    end
  end

  // Readback data register.
  always_ff @(posedge clk) begin
    if (reset_poweron) rd_data_q <= '0;
    else               rd_data_q <= rd_data_d;
  end

  assign simd__cntl__rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_simd_cfg_bridge.sv
// tb/tb_simd_cfg_bridge.sv - directed self-checking bench for simd_cfg_bridge
`ifndef PE_PE_ID_RANGE
`define PE_PE_ID_RANGE 7:0
`endif

module tb_simd_cfg_bridge;

  logic                   clk = 1'b0;
  logic                   reset_poweron;
  logic [`PE_PE_ID_RANGE] peId;
  logic                   wr_valid;
  logic [2:0]             wr_addr;
  logic [31:0]            wr_data;
  logic                   commit;
  logic [31:0]            lane_mask;
  logic                   busy, idle, commit_drop, err, valid;
  logic [255:0]           cfg;
  logic [31:0]            lane_en;
  logic [7:0]             tag;
  logic                   ready, done;
`ifdef SIMD_CFG_BRIDGE_READBACK_EN
  logic [2:0]             rd_addr;
  logic [31:0]            rd_data;
`endif

  int total = 0;
  int bad   = 0;

  simd_cfg_bridge dut (
    .clk                     (clk),
    .reset_poweron           (reset_poweron),
    .peId                    (peId),
    .cntl__simd__wr_valid    (wr_valid),
    .cntl__simd__wr_addr     (wr_addr),
    .cntl__simd__wr_data     (wr_data),
    .cntl__simd__commit      (commit),
    .cntl__simd__lane_mask   (lane_mask),
    .simd__cntl__busy        (busy),
    .simd__cntl__idle        (idle),
    .simd__cntl__commit_drop (commit_drop),
    .simd__cntl__err         (err),
    .simd__stOp__valid       (valid),
    .simd__stOp__cfg         (cfg),
    .simd__stOp__lane_en     (lane_en),
    .simd__stOp__tag         (tag),
    .stOp__simd__ready       (ready),
    .stOp__simd__done        (done)
`ifdef SIMD_CFG_BRIDGE_READBACK_EN
    ,
    .cntl__simd__rd_addr     (rd_addr),
    .simd__cntl__rd_data     (rd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_poweron = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; lane_mask = '0; ready = 1'b0; done = 1'b0;
    tick();
    reset_poweron = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_mask;
    int pops;
    peId = 8'h3C;
`ifdef SIMD_CFG_BRIDGE_READBACK_EN
    rd_addr = '0;
`endif
    do_reset();
    tick();

    // reset state
    check("rst_valid", valid, 0);
    check("rst_cfg", cfg, 0);
    check("rst_lane_en", lane_en, 0);
    check("rst_tag", tag, 0);
    check("rst_busy", busy, 0);
    check("rst_idle", idle, 1);
    check("rst_drop", commit_drop, 0);
    check("rst_err", err, 0);

    // basic write / commit / dispatch
    wr_valid = 1; wr_addr = 0; wr_data = 32'hA5A5A5A5; tick();
    wr_addr = 7; wr_data = 32'h1; tick();
    wr_valid = 0;
    commit = 1; lane_mask = 32'hF; ready = 1; tick();
    commit = 0;
    check("basic_valid", valid, 1);
    check("basic_reg0", cfg[31:0], 32'hA5A5A5A5);
    check("basic_reg7", cfg[255:224], 32'h1);
    check("basic_lane", lane_en, 32'hF);
    check("basic_tag", tag, 0);
    check("basic_idle_q", idle, 0);
    tick();
    check("basic_popped", valid, 0);
    check("basic_idle_out", idle, 0);
    done = 1; tick(); done = 0;
    check("basic_idle_done", idle, 1);
    check("basic_err", err, 0);

    // fill, overflow, push+pop at full, ordered drain
    do_reset();
    for (int k = 0; k < 5; k++) begin
      commit = 1; lane_mask = k + 1; tick();
      if (k == 3) begin
        check("fill_busy4", busy, 1);
        check("fill_drop4", commit_drop, 0);
      end
    end
    check("fill_drop5", commit_drop, 1);
    check("fill_busy5", busy, 1);
    commit = 1; lane_mask = 32'h50; ready = 1;
    check("full_tag0", tag, 0);
    check("full_lane0", lane_en, 1);
    tick();
    commit = 0;
    check("full_pp_drop", commit_drop, 0);
    check("full_pp_busy", busy, 1);
    for (int k = 1; k < 5; k++) begin
      exp_mask = (k < 4) ? 32'(k + 1) : 32'h50;
      check("drain_valid", valid, 1);
      check("drain_tag", tag, k);
      check("drain_lane", lane_en, exp_mask);
      tick();
    end
    check("drain_empty", valid, 0);

    // outstanding limit
    do_reset();
    commit = 1; ready = 1; pops = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 16) commit = 0;
      if (valid) pops++;
      tick();
    end
    check("lim_pops", pops, 15);
    check("lim_valid_low", valid, 0);
    check("lim_not_idle", idle, 0);
    done = 1; tick(); done = 0;
    check("lim_valid_back", valid, 1);
    check("lim_tag", tag, 15);
    done = 1; commit = 1; tick(); done = 0; commit = 0;
    check("lim_pop_done", valid, 1);
    check("lim_tag16", tag, 16);
    tick();
    check("lim_relimit", valid, 0);

    // done with nothing outstanding
    do_reset();
    done = 1; tick(); done = 0;
    check("err_set", err, 1);
    check("err_idle", idle, 1);
    tick(); tick();
    check("err_sticky", err, 1);
    commit = 1; ready = 1; tick(); commit = 0; tick();
    check("err_out1", idle, 0);
    done = 1; tick(); done = 0;
    check("err_out0", idle, 1);
    check("err_still", err, 1);
    do_reset();
    check("err_cleared", err, 0);

    // write-through into snapshot
    wr_valid = 1; wr_addr = 2; wr_data = 32'h55; commit = 1; tick();
    wr_valid = 0; commit = 0;
    check("wt_valid", valid, 1);
    check("wt_reg2", cfg[95:64], 32'h55);
    check("wt_reg1", cfg[63:32], 0);
`ifdef SIMD_CFG_BRIDGE_READBACK_EN
    rd_addr = 2; tick();
    check("rb_reg2", rd_data, 32'h55);
`endif

    // sequence tag wrap
    do_reset();
    for (int k = 0; k < 257; k++) begin
      commit = 1; tick(); commit = 0;
      if (k == 255) check("wrap_255", tag, 255);
      if (k == 256) check("wrap_0", tag, 0);
      ready = 1; tick(); ready = 0;
      done = 1; tick(); done = 0;
    end
    check("wrap_err", err, 0);
    check("wrap_idle", idle, 1);

    // reset during a stalled handshake
    do_reset();
    wr_valid = 1; wr_addr = 1; wr_data = 32'h1234; commit = 1; lane_mask = 32'h3; tick();
    wr_valid = 0; commit = 0;
    check("mid_pre_valid", valid, 1);
    check("mid_pre_cfg", cfg[63:32], 32'h1234);
`ifdef SIMD_CFG_BRIDGE_READBACK_EN
    rd_addr = 1; tick();
    check("mid_pre_rb", rd_data, 32'h1234);
`endif
    reset_poweron = 1; tick(); reset_poweron = 0;
    check("mid_valid", valid, 0);
    check("mid_idle", idle, 1);
    check("mid_tag", tag, 0);
    check("mid_cfg", cfg, 0);
`ifdef SIMD_CFG_BRIDGE_READBACK_EN
    check("mid_rb", rd_data, 0);
`endif
    commit = 1; tick(); commit = 0;
    check("mid_shadow_clr", cfg[63:32], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
